// File: rtl/eer_pkg.sv
// Shared packet-type codes and heartbeat-lock state encoding for the EER-RL node.
package eer_pkg;

  localparam logic [2:0] PKT_HB   = 3'b000;
  localparam logic [2:0] PKT_CHE  = 3'b001;
  localparam logic [2:0] PKT_TS   = 3'b100;
  localparam logic [2:0] PKT_DATA = 3'b101;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } hb_state_e;

endpackage

// File: rtl/low_energy_monitor.sv
// Debounced low-energy detector with hysteresis against a buffered threshold.
module low_energy_monitor #(
  parameter int            W        = 16,
  parameter logic [W-1:0]  HYST     = 8,
  parameter int            DEBOUNCE = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] energy,
  input  logic [W-1:0] thr,
  output logic         low_E
);

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE - 1);

  logic [W:0]   hyst_sum;
  logic [W-1:0] clr_bound;
  logic         set_cond;
  logic         clr_cond;
  logic         opposing;
  logic [3:0]   cnt;

  // The upper bound saturates so a threshold near full scale cannot wrap low.
  always_comb begin
    hyst_sum  = {1'b0, thr} + {1'b0, HYST};
    clr_bound = hyst_sum[W] ? '1 : hyst_sum[W-1:0];
    set_cond  = (energy < thr);
    clr_cond  = (energy >= clr_bound);
    opposing  = low_E ? clr_cond : set_cond;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      low_E <= 1'b0;
    end else if (opposing) begin
      if (cnt == DEB_LAST) begin
        low_E <= ~low_E;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/node_info_regs.sv
// Per-node info registers: HB context, role, timeslot, Q-value, HB-lock FSM and low-energy flag.
// Optional HB-lock auto-unlock timer is enabled by defining HBLOCK_TIMEOUT_EN.
module node_info_regs
  import eer_pkg::*;
#(
  parameter int            W          = 16,
  parameter logic [W-1:0]  NODE_ID    = 'h000C,
  parameter logic [W-1:0]  HYST       = 'd8,
  parameter int            DEBOUNCE   = 3,
  parameter int            HB_TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_MNI,
  input  logic [2:0]   fPktType,
  input  logic [W-1:0] e_max,
  input  logic [W-1:0] e_min,
  input  logic [W-1:0] e_threshold,
  input  logic [W-1:0] hops,
  input  logic [W-1:0] ch_ID,
  input  logic [W-1:0] timeslot,
  input  logic [W-1:0] energy,
  input  logic [W-1:0] q_in,
  input  logic         q_valid,
  output logic [W-1:0] myNodeID,
  output logic [W-1:0] hopsFromSink,
  output logic [W-1:0] myQValue,
  output logic [W-1:0] myTimeslot,
  output logic [W-1:0] eMax,
  output logic [W-1:0] eMin,
  output logic         role,
  output logic         low_E,
  output logic         hb_locked
);

  hb_state_e    state;
  hb_state_e    state_next;
  logic [W-1:0] thr_buf;
  logic         hb_cap;
  logic         che_cap;
  logic         ts_cap;
  logic         data_seen;
  logic         timeout_hit;

  assign myNodeID  = NODE_ID;
  assign hb_locked = (state == LOCKED);
  assign hb_cap    = en_MNI && (fPktType == PKT_HB);
  assign che_cap   = en_MNI && (fPktType == PKT_CHE);
  assign ts_cap    = en_MNI && (fPktType == PKT_TS);
  assign data_seen = (fPktType == PKT_DATA);

`ifdef HBLOCK_TIMEOUT_EN
  logic [W-1:0] hb_timer;

  always_ff @(posedge clk) begin
    if (rst || state == UNLOCKED) begin
      hb_timer <= '0;
    end else begin
      hb_timer <= hb_timer + 1'b1;
    end
  end

  assign timeout_hit = (state == LOCKED) && (hb_timer == W'(HB_TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UNLOCKED;
    end else begin
      state <= state_next;
    end
  end

  // DATA (or timeout) wins; an HB only locks from the unlocked state.
  always_comb begin
    state_next = state;
    if (data_seen || timeout_hit) begin
      state_next = UNLOCKED;
    end else if (state == UNLOCKED && hb_cap) begin
      state_next = LOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hopsFromSink <= '0;
      eMax         <= '0;
      eMin         <= '0;
      thr_buf      <= '0;
      role         <= 1'b0;
      myTimeslot   <= '0;
      myQValue     <= '0;
    end else begin
      if (hb_cap) begin
        hopsFromSink <= hops;
      end
      if (hb_cap && state == UNLOCKED) begin
        eMax    <= e_max;
        eMin    <= e_min;
        thr_buf <= e_threshold;
      end
      if (che_cap) begin
        role <= (ch_ID == NODE_ID);
      end
      if (ts_cap) begin
        myTimeslot <= timeslot;
      end
      if (q_valid) begin
        myQValue <= q_in;
      end
    end
  end

  low_energy_monitor #(
    .W        (W),
    .HYST     (HYST),
    .DEBOUNCE (DEBOUNCE)
  ) u_low_energy_monitor (
    .clk    (clk),
    .rst    (rst),
    .energy (energy),
    .thr    (thr_buf),
    .low_E  (low_E)
  );

endmodule
